alu_share_arbiter: RTL and testbench

//  Shares one 5-bit four-function ALU between two requesters.

---
 rtl/alu_share_pkg.sv | 18 +
 rtl/alu_op_unit.sv | 39 +++
 rtl/alu_share_arbiter.sv | 153 +++++++++++++++
 tb/tb_alu_share_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/alu_share_pkg.sv
// alu_share_pkg
//   Shared encodings for the two-requester ALU share arbiter:
//   ALU operation selects and the output-register FSM states.
package alu_share_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_ADD = 2'b01,
        OP_OR  = 2'b10,
        OP_XOR = 2'b11
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,  // output register empty
        ST_FULL = 1'b1   // output register holds a result for the consumer
    } state_e;

endpackage

// File: rtl/alu_op_unit.sv
// alu_op_unit
//   Combinational WIDTH-bit four-function ALU (AND / ADD / OR / XOR).
//   Ports:
//     a, b    in   WIDTH  operands
//     op      in   op_e   operation select
//     result  out  WIDTH  operation result (ADD wraps modulo 2^WIDTH)
//     carry   out  1      carry-out of ADD, 0 for the bitwise ops
module alu_op_unit
    import alu_share_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_e              op,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    logic [WIDTH:0] sum;

    assign sum = {1'b0, a} + {1'b0, b};

    always_comb begin
        result = '0;
        carry  = 1'b0;
        unique case (op)
            OP_AND: result = a & b;
            OP_ADD: begin
                result = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
            end
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one alu_op_unit between two requesters. Requests are granted
//   round-robin, the result is held in a one-entry output register and
//   returned on a single response channel tagged with the requester id.
//   Ports:
//     clk, reset   clock; synchronous active-high reset
//     req_valid    in   2        per-requester valid
//     req_ready    out  2        per-requester accept (one-hot or zero)
//     req_a/req_b  in   2*WIDTH  operands, requester i at [i*WIDTH +: WIDTH]
//     req_sel      in   4        op select, requester i at [2i +: 2]
//     resp_valid   out  1        held result valid
//     resp_ready   in   1        consumer accepts result
//     resp_data    out  WIDTH    held result
//     resp_id      out  1        requester owning resp_data
//     op_count     out  CNT_W    accepted-request counter (wraps)
//     resp_carry   out  1        ADD carry-out, only with ALU_SHARE_CARRY_OUT_EN
//   Build option: define ALU_SHARE_CARRY_OUT_EN to add resp_carry.
module alu_share_arbiter
    import alu_share_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [2*WIDTH-1:0] req_a,
    input  logic [2*WIDTH-1:0] req_b,
    input  logic [3:0]         req_sel,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [WIDTH-1:0]   resp_data,
    output logic               resp_id,
    output logic [CNT_W-1:0]   op_count
`ifdef ALU_SHARE_CARRY_OUT_EN
    ,
    output logic               resp_carry
`endif
);

    state_e             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic [WIDTH-1:0]   resp_data_q, resp_data_d;
    logic               resp_id_q, resp_id_d;
    logic [CNT_W-1:0]   op_count_q, op_count_d;

    logic               can_acc;
    logic               grant;
    logic               accept;
    logic [WIDTH-1:0]   mux_a, mux_b;
    logic [1:0]         mux_sel;
    logic [WIDTH-1:0]   alu_result;

    // Winner: a lone valid requester wins; on contention the one not
    // granted last time wins. With nothing valid the value is unused.
    always_comb begin
        unique case (req_valid)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_grant_q;
            default: grant = 1'b0;
        endcase
    end

    // A full register can reload in the same cycle it drains.
    assign can_acc = (state_q == ST_IDLE) | resp_ready;
    assign accept  = can_acc & (|req_valid);

    always_comb begin
        req_ready        = 2'b00;
        req_ready[grant] = accept;
    end

    assign mux_a   = grant ? req_a[WIDTH +: WIDTH] : req_a[0 +: WIDTH];
    assign mux_b   = grant ? req_b[WIDTH +: WIDTH] : req_b[0 +: WIDTH];
    assign mux_sel = grant ? req_sel[3:2]          : req_sel[1:0];

`ifdef ALU_SHARE_CARRY_OUT_EN
    logic alu_carry;
    logic resp_carry_q, resp_carry_d;
`else
    logic alu_carry_unused;
`endif

    alu_op_unit #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a      (mux_a),
        .b      (mux_b),
        .op     (op_e'(mux_sel)),
        .result (alu_result),
`ifdef ALU_SHARE_CARRY_OUT_EN
        .carry  (alu_carry)
`else
        .carry  (alu_carry_unused)
`endif
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        resp_data_d  = resp_data_q;
        resp_id_d    = resp_id_q;
        op_count_d   = op_count_q;
`ifdef ALU_SHARE_CARRY_OUT_EN
        resp_carry_d = resp_carry_q;
`endif
        if (accept) begin
            state_d      = ST_FULL;
            last_grant_d = grant;
            resp_data_d  = alu_result;
            resp_id_d    = grant;
            op_count_d   = op_count_q + CNT_W'(1);
`ifdef ALU_SHARE_CARRY_OUT_EN
            resp_carry_d = alu_carry;
`endif
        end else if (state_q == ST_FULL && resp_ready) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;  // requester 0 wins the first contention
            resp_data_q  <= '0;
            resp_id_q    <= 1'b0;
            op_count_q   <= '0;
`ifdef ALU_SHARE_CARRY_OUT_EN
            resp_carry_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            resp_data_q  <= resp_data_d;
            resp_id_q    <= resp_id_d;
            op_count_q   <= op_count_d;
`ifdef ALU_SHARE_CARRY_OUT_EN
            resp_carry_q <= resp_carry_d;
`endif
        end
    end

    assign resp_valid = (state_q == ST_FULL);
    assign resp_data  = resp_data_q;
    assign resp_id    = resp_id_q;
    assign op_count   = op_count_q;
`ifdef ALU_SHARE_CARRY_OUT_EN
    assign resp_carry = resp_carry_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter
//   Directed vectors with hand-computed expectations for alu_share_arbiter.
//   Inputs change 1ns after the rising edge; outputs are checked mid-cycle.
module tb_alu_share_arbiter;

    localparam int WIDTH = 5;
    localparam int CNT_W = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [2*WIDTH-1:0] req_a;
    logic [2*WIDTH-1:0] req_b;
    logic [3:0]         req_sel;
    logic               resp_valid;
    logic               resp_ready;
    logic [WIDTH-1:0]   resp_data;
    logic               resp_id;
    logic [CNT_W-1:0]   op_count;
`ifdef ALU_SHARE_CARRY_OUT_EN
    logic               resp_carry;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_sel    (req_sel),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .op_count   (op_count)
`ifdef ALU_SHARE_CARRY_OUT_EN
        ,
        .resp_carry (resp_carry)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // advance one clock and settle past the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [4:0] a, input logic [4:0] b, input logic [1:0] s);
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
        req_sel[2*i +: 2]       = s;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = 2'b00;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req_valid = 2'b00; resp_ready = 1'b1;
        req_a = '0; req_b = '0; req_sel = '0;
        #1;
        do_reset();

        // reset state
        chk("rst_valid", 32'(resp_valid), 32'h0);
        chk("rst_data",  32'(resp_data),  32'h0);
        chk("rst_id",    32'(resp_id),    32'h0);
        chk("rst_count", 32'(op_count),   32'h0);

        // 1: single request, AND
        set_req(0, 5'h0C, 5'h0A, 2'b00);
        req_valid = 2'b01;
        #1 chk("t1_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 2'b00;
        chk("t1_valid", 32'(resp_valid), 32'h1);
        chk("t1_data",  32'(resp_data),  32'h08);
        chk("t1_id",    32'(resp_id),    32'h0);
        chk("t1_count", 32'(op_count),   32'h1);
        #1 chk("t1_drain_ready", 32'(req_ready), 32'h0);
        tick();
        chk("t1_idle", 32'(resp_valid), 32'h0);

        // 2: contention from reset, ADD wrap then XOR, back-to-back
        do_reset();
        set_req(0, 5'h1F, 5'h02, 2'b01);
        set_req(1, 5'h15, 5'h0F, 2'b11);
        req_valid = 2'b11;
        #1 chk("t2_ready0", 32'(req_ready), 32'h1);
        tick();
        req_valid = 2'b10;
        chk("t2_data0", 32'(resp_data), 32'h01);
        chk("t2_id0",   32'(resp_id),   32'h0);
        #1 chk("t2_ready1", 32'(req_ready), 32'h2);
        tick();
        req_valid = 2'b00;
        chk("t2_valid1", 32'(resp_valid), 32'h1);
        chk("t2_data1",  32'(resp_data),  32'h1A);
        chk("t2_id1",    32'(resp_id),    32'h1);
        chk("t2_count",  32'(op_count),   32'h2);

        // 3: both valid for 6 cycles -> alternating grants
        do_reset();
        set_req(0, 5'h0C, 5'h0A, 2'b00);
        set_req(1, 5'h15, 5'h0F, 2'b11);
        req_valid = 2'b11;
        for (int i = 0; i < 6; i++) begin
            #1 chk("t3_ready", 32'(req_ready), (i % 2) ? 32'h2 : 32'h1);
            tick();
            chk("t3_id",   32'(resp_id),   32'(i % 2));
            chk("t3_data", 32'(resp_data), (i % 2) ? 32'h1A : 32'h08);
        end
        chk("t3_count", 32'(op_count), 32'h6);

        // 4: backpressure while FULL with r1 pending (new r1 op: 03 OR 14)
        set_req(1, 5'h03, 5'h14, 2'b10);
        req_valid  = 2'b10;
        resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("t4_stall_ready", 32'(req_ready), 32'h0);
            tick();
            chk("t4_hold_data",  32'(resp_data),  32'h1A);
            chk("t4_hold_valid", 32'(resp_valid), 32'h1);
        end
        resp_ready = 1'b1;
        #1 chk("t4_ready", 32'(req_ready), 32'h2);
        tick();
        chk("t4_data",  32'(resp_data), 32'h17);
        chk("t4_id",    32'(resp_id),   32'h1);
        chk("t4_count", 32'(op_count),  32'h7);

        // 5: reset while FULL with both pending; r0 now ORs
        set_req(0, 5'h0C, 5'h0A, 2'b10);
        req_valid  = 2'b11;
        resp_ready = 1'b0;
        reset      = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_valid", 32'(resp_valid), 32'h0);
        chk("t5_count", 32'(op_count),   32'h0);
        resp_ready = 1'b1;
        #1 chk("t5_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 2'b00;
        chk("t5_id",    32'(resp_id),   32'h0);
        chk("t5_data",  32'(resp_data), 32'h0E);
        chk("t5_count1", 32'(op_count), 32'h1);

`ifdef ALU_SHARE_CARRY_OUT_EN
        // 6: carry-out register
        tick();
        set_req(0, 5'h10, 5'h10, 2'b01);
        req_valid = 2'b01;
        tick();
        chk("t6_add_data",  32'(resp_data),  32'h00);
        chk("t6_add_carry", 32'(resp_carry), 32'h1);
        set_req(0, 5'h10, 5'h10, 2'b10);
        tick();
        req_valid = 2'b00;
        chk("t6_or_data",  32'(resp_data),  32'h10);
        chk("t6_or_carry", 32'(resp_carry), 32'h0);
`endif

        tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
